regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 67 ++++++
 tb/tb_regfile_sb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read/2-write register file with a load-pending scoreboard and popcount.
// Define REGFILE_BYPASS_EN to forward same-cycle write data and busy clears to the read ports.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_busy_1,
  output logic              rd_busy_2,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic [ADDR_W:0]   busy_cnt
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_cnt;
  logic w_wa, w_wb, w_iss, w_set, w_clr;
  assign w_wa  = wa_en && wa_addr != '0;
  assign w_wb  = wb_en && wb_addr != '0;
  assign w_iss = iss_en && iss_addr != '0;
  // counter moves only on real busy transitions, so it always tracks the popcount
  assign w_set = w_iss && !r_busy[iss_addr];
  assign w_clr = w_wb && r_busy[wb_addr] && !(w_iss && iss_addr == wb_addr);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wa && !(w_wb && wa_addr == wb_addr)) r_mem[wa_addr] <= wa_data;
      if (w_wb) r_mem[wb_addr] <= wb_data;
      if (w_clr) r_busy[wb_addr] <= 1'b0;
      if (w_set) r_busy[iss_addr] <= 1'b1;
      r_cnt <= r_cnt + {{ADDR_W{1'b0}}, w_set} - {{ADDR_W{1'b0}}, w_clr};
    end
  function automatic logic [DATA_W-1:0] f_data(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return (w_wb && wb_addr == a) ? wb_data : (w_wa && wa_addr == a) ? wa_data : r_mem[a];
`else
    return r_mem[a];
`endif
  endfunction
  function automatic logic f_busy(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return (w_wb && wb_addr == a && !(w_iss && iss_addr == a)) ? 1'b0 : r_busy[a];
`else
    return r_busy[a];
`endif
  endfunction
  assign rd_data_1 = rst ? f_data(rd_addr_1) : '0;
  assign rd_data_2 = rst ? f_data(rd_addr_2) : '0;
  assign rd_busy_1 = rst && f_busy(rd_addr_1);
  assign rd_busy_2 = rst && f_busy(rd_addr_2);
  assign busy_cnt  = r_cnt;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against an array-based reference model.
module tb_regfile_sb;
  localparam int DW = 32, AW = 5, N = 32;
  logic clk = 0, rst = 0;
  logic [AW-1:0] rd_addr_1 = '0, rd_addr_2 = '0, wa_addr = '0, wb_addr = '0, iss_addr = '0;
  logic [DW-1:0] rd_data_1, rd_data_2, wa_data = '0, wb_data = '0;
  logic rd_busy_1, rd_busy_2, wa_en = 0, wb_en = 0, iss_en = 0;
  logic [AW:0] busy_cnt;
  int cmp = 0, bad = 0;
  logic [DW-1:0] m_mem [N];
  bit m_busy [N];
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
    .rd_busy_1(rd_busy_1), .rd_busy_2(rd_busy_2),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(busy_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] e_rd(input int a);
    if (!rst) return '0;
`ifdef REGFILE_BYPASS_EN
    if (a != 0 && wb_en && int'(wb_addr) == a) return wb_data;
    if (a != 0 && wa_en && int'(wa_addr) == a) return wa_data;
`endif
    return m_mem[a];
  endfunction
  function automatic logic e_bsy(input int a);
    if (!rst) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (a != 0 && wb_en && int'(wb_addr) == a && !(iss_en && int'(iss_addr) == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction
  function automatic int e_cnt();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(m_busy[i]);
    return c;
  endfunction
  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 0;
    end
  endtask
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    cmp++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("rd_data_1", rd_data_1, e_rd(int'(rd_addr_1)));
    chk("rd_data_2", rd_data_2, e_rd(int'(rd_addr_2)));
    chk("rd_busy_1", {31'b0, rd_busy_1}, {31'b0, e_bsy(int'(rd_addr_1))});
    chk("rd_busy_2", {31'b0, rd_busy_2}, {31'b0, e_bsy(int'(rd_addr_2))});
    chk("busy_cnt", {26'b0, busy_cnt}, DW'(e_cnt()));
  endtask
  // load port beats ALU port on data; a new issue beats a same-cycle return on busy
  task automatic model_clk();
    if (!rst) model_clear();
    else begin
      if (wa_en && wa_addr != 0) m_mem[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) m_mem[wb_addr] = wb_data;
      if (wb_en && wb_addr != 0) m_busy[wb_addr] = 0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_clk();
    #1;
  endtask
  task automatic idle();
    wa_en = 0;
    wb_en = 0;
    iss_en = 0;
  endtask
  task automatic wr_a(input int a, input logic [DW-1:0] d);
    wa_en = 1; wa_addr = AW'(a); wa_data = d;
  endtask
  task automatic wr_b(input int a, input logic [DW-1:0] d);
    wb_en = 1; wb_addr = AW'(a); wb_data = d;
  endtask
  task automatic issue(input int a);
    iss_en = 1; iss_addr = AW'(a);
  endtask
  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd", rd_data_1, 32'h0);
    chk("reset_cnt", {26'b0, busy_cnt}, 32'h0);
    #2 rst = 1;
    @(posedge clk);
    #1;
    wr_a(0, 32'hFFFF_FFFF); issue(0); rd_addr_1 = 0; rd_addr_2 = 0;
    tick();
    idle();
    #1;
    chk("zero_rd", rd_data_1, 32'h0);
    chk("zero_busy", {31'b0, rd_busy_1}, 32'h0);
    chk("zero_cnt", {26'b0, busy_cnt}, 32'h0);
    wr_a(7, 32'h11); wr_b(7, 32'h22); rd_addr_1 = 7;
    tick();
    idle();
    #1;
    chk("collide_r7", rd_data_1, 32'h22);
    issue(3); tick();
    issue(4); tick();
    idle();
    #1;
    chk("sb_cnt2", {26'b0, busy_cnt}, 32'd2);
    wr_b(3, 32'hAB); rd_addr_1 = 3; rd_addr_2 = 4;
    tick();
    idle();
    #1;
    chk("sb_cnt1", {26'b0, busy_cnt}, 32'd1);
    chk("sb_busy3", {31'b0, rd_busy_1}, 32'h0);
    chk("sb_r3", rd_data_1, 32'hAB);
    issue(4); tick();
    idle();
    #1;
    chk("sb_reissue", {26'b0, busy_cnt}, 32'd1);
    issue(9); tick();
    issue(9); wr_b(9, 32'h55); rd_addr_1 = 9;
    tick();
    idle();
    #1;
    chk("race_r9", rd_data_1, 32'h55);
    chk("race_busy", {31'b0, rd_busy_1}, 32'h1);
    chk("race_cnt", {26'b0, busy_cnt}, 32'd2);
    wr_a(2, 32'h33); tick();
    idle();
    wr_b(2, 32'h77); rd_addr_1 = 2;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass", rd_data_1, 32'h77);
`else
    chk("bypass", rd_data_1, 32'h33);
`endif
    tick();
    idle();
    wr_a(5, 32'h1234); tick();
    idle();
    rd_addr_1 = 5; rd_addr_2 = 9;
    #2 rst = 0;
    #1;
    model_clear();
    chk("async_rd5", rd_data_1, 32'h0);
    chk("async_cnt", {26'b0, busy_cnt}, 32'h0);
    chk("async_busy9", {31'b0, rd_busy_2}, 32'h0);
    wr_a(5, 32'hFF); issue(6);
    tick();
    idle();
    #2 rst = 1;
    tick();
    issue(6); tick();
    idle();
    #1;
    chk("post_rst_r5", rd_data_1, 32'h0);
    chk("post_rst_cnt", {26'b0, busy_cnt}, 32'd1);
    for (int k = 0; k < 400; k++) begin
      wa_en = 1'($urandom); wa_addr = AW'($urandom_range(0, 15)); wa_data = $urandom;
      wb_en = 1'($urandom); wb_addr = AW'($urandom_range(0, 15)); wb_data = $urandom;
      iss_en = 1'($urandom); iss_addr = AW'($urandom_range(0, 15));
      rd_addr_1 = AW'($urandom_range(0, 31)); rd_addr_2 = AW'($urandom_range(0, 15));
      tick();
    end
    idle();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
